// File: rtl/jtframe_ba_arbiter_if.sv
// jtframe_ba_arbiter_if: per-slot request/response signals plus the SDRAM bank read port.
// master = arbiter side, slave = game logic and bank side.
interface jtframe_ba_arbiter_if #(
    parameter int SLOTS = 4,
    parameter int AW    = 22
);
    logic [SLOTS*AW-1:0] slot_addr;
    logic [SLOTS-1:0]    slot_cs;
    logic [SLOTS-1:0]    slot_ok;
    logic [SLOTS*16-1:0] slot_dout;
    logic [AW-1:0]       ba_addr;
    logic                ba_rd;
    logic                ba_ack;
    logic                ba_rdy;
    logic [15:0]         sdram_dout;

    modport master (
        input  slot_addr, slot_cs, ba_ack, ba_rdy, sdram_dout,
        output slot_ok, slot_dout, ba_addr, ba_rd
    );

    modport slave (
        output slot_addr, slot_cs, ba_ack, ba_rdy, sdram_dout,
        input  slot_ok, slot_dout, ba_addr, ba_rd
    );
endinterface

// File: rtl/jtframe_ba_arbiter.sv
// jtframe_ba_arbiter: round-robin sharing of one SDRAM bank read port between SLOTS one-word slots.
// Define JTFRAME_BA_ARB_CACHE_EN to keep each slot's word valid while its cs is low.
module jtframe_ba_arbiter #(
    parameter int SLOTS = 4,
    parameter int AW    = 22
) (
    input logic                 clk,
    input logic                 rst_n,
    jtframe_ba_arbiter_if.master bus
);
    localparam int GW = $clog2(SLOTS);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;

    state_t              state, state_nx;
    logic [AW-1:0]       tag [SLOTS];
    logic [15:0]         data [SLOTS];
    logic [SLOTS-1:0]    valid, hit, pend;
    logic [GW-1:0]       rr_ptr, gnt, pick;
    logic [GW:0]         idx;
    logic [AW-1:0]       req_addr;
    logic                req_rd, found, issue, done, busy;
    logic [SLOTS*16-1:0] dout_flat;

    assign busy          = state != IDLE;
    assign bus.ba_addr   = req_addr;
    assign bus.ba_rd     = req_rd;
    assign bus.slot_ok   = bus.slot_cs & hit;
    assign bus.slot_dout = dout_flat;

    // The slot being served is not pending, so it cannot be granted twice
    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        assign hit[i]  = valid[i] && tag[i] == bus.slot_addr[i*AW +: AW];
        assign pend[i] = bus.slot_cs[i] && !hit[i] && !(busy && gnt == GW'(i));
    end

    always_comb begin
        dout_flat = '0;
        for (int i = 0; i < SLOTS; i++) dout_flat[i*16 +: 16] = data[i];
    end

    // Search starts just after the last winner, so the winner drops to lowest priority
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 1; k <= SLOTS; k++) begin
            idx = {1'b0, rr_ptr} + (GW+1)'(k);
            idx = idx >= (GW+1)'(SLOTS) ? idx - (GW+1)'(SLOTS) : idx;
            if (!found && pend[idx[GW-1:0]]) begin
                found = 1'b1;
                pick  = idx[GW-1:0];
            end
        end
    end

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                issue    = found;
                state_nx = found ? WAIT_ACK : IDLE;
            end
            WAIT_ACK: begin
                done     = bus.ba_ack && bus.ba_rdy;
                state_nx = !bus.ba_ack ? WAIT_ACK : bus.ba_rdy ? IDLE : WAIT_RDY;
            end
            WAIT_RDY: begin
                done     = bus.ba_rdy;
                state_nx = bus.ba_rdy ? IDLE : WAIT_RDY;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= GW'(SLOTS-1);
            gnt      <= '0;
            req_addr <= '0;
            req_rd   <= 1'b0;
            valid    <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                tag[i]  <= '0;
                data[i] <= '0;
            end
        end else begin
            state <= state_nx;
            if (issue) begin
                gnt      <= pick;
                rr_ptr   <= pick;
                req_addr <= bus.slot_addr[int'(pick)*AW +: AW];
                req_rd   <= 1'b1;
            end else if (state == WAIT_ACK && bus.ba_ack) begin
                req_rd <= 1'b0;
            end
`ifdef JTFRAME_BA_ARB_CACHE_EN
            valid <= valid;
`else
            valid <= valid & bus.slot_cs;
`endif
            if (done) begin
                tag[gnt]   <= req_addr;
                data[gnt]  <= bus.sdram_dout;
                valid[gnt] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_jtframe_ba_arbiter.sv
// tb_jtframe_ba_arbiter: directed checks of the bank arbiter with a hand-timed bank model.
module tb_jtframe_ba_arbiter;
    localparam int SLOTS = 4;
    localparam int AW    = 22;

    logic clk = 1'b0;
    logic rst_n;
    int   passed = 0;
    int   total  = 0;

    jtframe_ba_arbiter_if #(.SLOTS(SLOTS), .AW(AW)) bus ();

    jtframe_ba_arbiter #(.SLOTS(SLOTS), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [AW-1:0] a, input logic cs);
        bus.slot_addr[i*AW +: AW] = a;
        bus.slot_cs[i] = cs;
    endtask

    // Bank model: waits for ba_rd, acks after ack_dly cycles, returns data rdy_dly cycles after ack
    task automatic serve(input int ack_dly, input int rdy_dly, input logic [15:0] d,
                         output logic [AW-1:0] a, output bit seen);
        seen = 1'b0;
        a    = '0;
        for (int n = 0; n < 40 && !seen; n++) begin
            if (bus.ba_rd) seen = 1'b1;
            else tick();
        end
        if (!seen) return;
        a = bus.ba_addr;
        repeat (ack_dly) tick();
        bus.ba_ack = 1'b1;
        if (rdy_dly == 0) begin
            bus.ba_rdy     = 1'b1;
            bus.sdram_dout = d;
        end
        tick();
        bus.ba_ack = 1'b0;
        bus.ba_rdy = 1'b0;
        if (rdy_dly > 0) begin
            repeat (rdy_dly-1) tick();
            bus.ba_rdy     = 1'b1;
            bus.sdram_dout = d;
            tick();
            bus.ba_rdy = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        total++; if (bus.ba_rd !== 1'b0) $display("FAIL reset_ba_rd got %b want 0", bus.ba_rd); else passed++;
        total++; if (bus.ba_addr !== 22'h0) $display("FAIL reset_ba_addr got %h want 0", bus.ba_addr); else passed++;
        total++; if (bus.slot_ok !== 4'h0) $display("FAIL reset_ok got %b want 0000", bus.slot_ok); else passed++;
        total++; if (bus.slot_dout !== 64'h0) $display("FAIL reset_dout got %h want 0", bus.slot_dout); else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        set_slot(0, 22'h100, 1'b1);
        tick();
        total++; if (bus.ba_rd !== 1'b1) $display("FAIL single_rd_issue got %b want 1", bus.ba_rd); else passed++;
        total++; if (bus.ba_addr !== 22'h100) $display("FAIL single_addr got %h want 100", bus.ba_addr); else passed++;
        tick();
        total++; if (bus.ba_rd !== 1'b1) $display("FAIL single_rd_hold got %b want 1", bus.ba_rd); else passed++;
        bus.ba_ack = 1'b1;
        tick();
        bus.ba_ack = 1'b0;
        total++; if (bus.ba_rd !== 1'b0) $display("FAIL single_rd_drop got %b want 0", bus.ba_rd); else passed++;
        repeat (3) tick();
        total++; if (bus.slot_ok[0] !== 1'b0) $display("FAIL single_ok_early got %b want 0", bus.slot_ok[0]); else passed++;
        bus.sdram_dout = 16'hBEEF;
        bus.ba_rdy     = 1'b1;
        tick();
        bus.ba_rdy = 1'b0;
        total++; if (bus.slot_ok[0] !== 1'b1) $display("FAIL single_ok got %b want 1", bus.slot_ok[0]); else passed++;
        total++; if (bus.slot_dout[15:0] !== 16'hBEEF) $display("FAIL single_dout got %h want BEEF", bus.slot_dout[15:0]); else passed++;
        tick();
        total++; if (bus.ba_rd !== 1'b0) $display("FAIL single_no_reissue got %b want 0", bus.ba_rd); else passed++;
        bus.slot_cs = '0;
        tick();
    endtask

    task automatic test_all_slots();
        logic [AW-1:0] a;
        bit            seen;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < SLOTS; k++) set_slot(k, AW'((k+1)*16), 1'b1);
        for (int k = 0; k < SLOTS; k++) begin
            serve(1, 2, 16'(16'hA000 + k), a, seen);
            total++; if (!seen) $display("FAIL all_timeout slot %0d no ba_rd", k); else passed++;
            total++; if (a !== AW'((k+1)*16)) $display("FAIL all_order got %h want %h", a, AW'((k+1)*16)); else passed++;
            total++; if (bus.slot_ok !== 4'((1 << (k+1)) - 1)) $display("FAIL all_ok got %b want %b", bus.slot_ok, 4'((1 << (k+1)) - 1)); else passed++;
            total++; if (bus.slot_dout[k*16 +: 16] !== 16'(16'hA000 + k)) $display("FAIL all_dout got %h want %h", bus.slot_dout[k*16 +: 16], 16'(16'hA000 + k)); else passed++;
            total++; if (bus.ba_rd !== 1'b0) $display("FAIL all_one_at_a_time got %b want 0", bus.ba_rd); else passed++;
        end
        bus.slot_cs = '0;
        tick();
    endtask

    task automatic test_ack_rdy_same();
        logic [AW-1:0] a;
        bit            seen;
        set_slot(3, 22'h55, 1'b1);
        serve(1, 0, 16'h1234, a, seen);
        total++; if (!seen || a !== 22'h55) $display("FAIL same_addr got %h want 55", a); else passed++;
        total++; if (bus.slot_ok[3] !== 1'b1) $display("FAIL same_ok got %b want 1", bus.slot_ok[3]); else passed++;
        total++; if (bus.slot_dout[63:48] !== 16'h1234) $display("FAIL same_dout got %h want 1234", bus.slot_dout[63:48]); else passed++;
        set_slot(2, 22'h66, 1'b1);
        tick();
        total++; if (bus.ba_rd !== 1'b1 || bus.ba_addr !== 22'h66) $display("FAIL same_idle_next got rd=%b addr=%h want rd=1 addr=66", bus.ba_rd, bus.ba_addr); else passed++;
        serve(0, 1, 16'h6666, a, seen);
        total++; if (bus.slot_ok[2] !== 1'b1) $display("FAIL same_next_ok got %b want 1", bus.slot_ok[2]); else passed++;
        bus.slot_cs = '0;
        tick();
    endtask

    task automatic test_addr_change();
        logic [AW-1:0] a;
        bit            seen;
        set_slot(1, 22'h200, 1'b1);
        for (int n = 0; n < 20 && !bus.ba_rd; n++) tick();
        total++; if (bus.ba_rd !== 1'b1 || bus.ba_addr !== 22'h200) $display("FAIL chg_first got rd=%b addr=%h want rd=1 addr=200", bus.ba_rd, bus.ba_addr); else passed++;
        bus.ba_ack = 1'b1;
        tick();
        bus.ba_ack = 1'b0;
        tick();
        set_slot(1, 22'h204, 1'b1);
        tick();
        bus.sdram_dout = 16'hAAAA;
        bus.ba_rdy     = 1'b1;
        tick();
        bus.ba_rdy = 1'b0;
        total++; if (bus.slot_ok[1] !== 1'b0) $display("FAIL chg_ok_stale got %b want 0", bus.slot_ok[1]); else passed++;
        serve(1, 1, 16'hBBBB, a, seen);
        total++; if (!seen || a !== 22'h204) $display("FAIL chg_reread got %h want 204", a); else passed++;
        total++; if (bus.slot_ok[1] !== 1'b1) $display("FAIL chg_ok got %b want 1", bus.slot_ok[1]); else passed++;
        total++; if (bus.slot_dout[31:16] !== 16'hBBBB) $display("FAIL chg_dout got %h want BBBB", bus.slot_dout[31:16]); else passed++;
        bus.slot_cs = '0;
        tick();
    endtask

    task automatic test_cache();
        logic [AW-1:0] a;
        bit            seen;
        set_slot(2, 22'h300, 1'b1);
        serve(1, 1, 16'hC0DE, a, seen);
        total++; if (bus.slot_ok[2] !== 1'b1) $display("FAIL cache_first_ok got %b want 1", bus.slot_ok[2]); else passed++;
        set_slot(2, 22'h300, 1'b0);
        repeat (2) tick();
        total++; if (bus.slot_ok[2] !== 1'b0) $display("FAIL cache_cs_low_ok got %b want 0", bus.slot_ok[2]); else passed++;
        set_slot(2, 22'h300, 1'b1);
        #1;
`ifdef JTFRAME_BA_ARB_CACHE_EN
        total++; if (bus.slot_ok[2] !== 1'b1) $display("FAIL cache_hit_ok got %b want 1", bus.slot_ok[2]); else passed++;
        total++; if (bus.slot_dout[47:32] !== 16'hC0DE) $display("FAIL cache_hit_dout got %h want C0DE", bus.slot_dout[47:32]); else passed++;
        repeat (2) tick();
        total++; if (bus.ba_rd !== 1'b0) $display("FAIL cache_no_read got %b want 0", bus.ba_rd); else passed++;
`else
        total++; if (bus.slot_ok[2] !== 1'b0) $display("FAIL cache_miss_ok got %b want 0", bus.slot_ok[2]); else passed++;
        tick();
        total++; if (bus.ba_rd !== 1'b1 || bus.ba_addr !== 22'h300) $display("FAIL cache_reread got rd=%b addr=%h want rd=1 addr=300", bus.ba_rd, bus.ba_addr); else passed++;
        serve(1, 1, 16'hC0DF, a, seen);
        total++; if (bus.slot_dout[47:32] !== 16'hC0DF) $display("FAIL cache_reread_dout got %h want C0DF", bus.slot_dout[47:32]); else passed++;
`endif
        bus.slot_cs = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] a;
        bit            seen;
        set_slot(3, 22'h77, 1'b1);
        serve(1, 1, 16'h7777, a, seen);
        total++; if (bus.slot_ok[3] !== 1'b1) $display("FAIL rst_pre_ok got %b want 1", bus.slot_ok[3]); else passed++;
        set_slot(0, 22'h111, 1'b1);
        for (int n = 0; n < 20 && !bus.ba_rd; n++) tick();
        bus.ba_ack = 1'b1;
        tick();
        bus.ba_ack = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.ba_rd !== 1'b0) $display("FAIL rst_async_rd got %b want 0", bus.ba_rd); else passed++;
        total++; if (bus.slot_ok !== 4'h0) $display("FAIL rst_async_ok got %b want 0000", bus.slot_ok); else passed++;
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (bus.ba_rd !== 1'b1 || bus.ba_addr !== 22'h111) $display("FAIL rst_restart got rd=%b addr=%h want rd=1 addr=111", bus.ba_rd, bus.ba_addr); else passed++;
        serve(1, 1, 16'h0111, a, seen);
        total++; if (bus.slot_ok[0] !== 1'b1 || bus.slot_dout[15:0] !== 16'h0111) $display("FAIL rst_restart_data got ok=%b dout=%h want ok=1 dout=0111", bus.slot_ok[0], bus.slot_dout[15:0]); else passed++;
        bus.slot_cs = '0;
        tick();
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.slot_addr  = '0;
        bus.slot_cs    = '0;
        bus.ba_ack     = 1'b0;
        bus.ba_rdy     = 1'b0;
        bus.sdram_dout = '0;
        test_reset();
        test_single();
        test_all_slots();
        test_ack_rdy_same();
        test_addr_change();
        test_cache();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
